// File: rtl/reg_file_wb_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_wb_sink_pkg
// Description : Shared widths and types for the write-back register file,
//               reused by the write stage and decode.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_wb_sink_pkg;

    localparam int c_DATA_W   = 16;
    localparam int c_ADDR_W   = 3;
    localparam int c_NUM_REGS = 2 ** c_ADDR_W;
    localparam int c_CNT_W    = 2;

    typedef logic [c_ADDR_W-1:0] reg_addr_t;
    typedef logic [c_DATA_W-1:0] data_word_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_wb_sink_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register pending-write counters, source/saturation hazard
//               detection, decode stall and sticky write-back error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import reg_file_wb_sink_pkg::*;
#(
    parameter int ADDR_W   = c_ADDR_W,
    parameter int CNT_W    = c_CNT_W,
    parameter int ZERO_REG = 0,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_wb_write,
    input  logic [ADDR_W-1:0]   i_wb_addr,
    input  logic [ADDR_W-1:0]   i_rs_addr,
    input  logic [ADDR_W-1:0]   i_rt_addr,
    input  logic                i_issue_valid,
    input  logic                i_issue_uses_rs,
    input  logic                i_issue_uses_rt,
    input  logic                i_issue_writes,
    input  logic [ADDR_W-1:0]   i_issue_rd,
    output logic                o_stall,
    output logic [NUM_REGS-1:0] o_pend_mask,
    output logic                o_sb_error
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]    r_cnt [NUM_REGS];
    logic                r_sb_error;

    logic                w_zr;
    logic                w_wb_tracked;
    logic                w_rs_tracked;
    logic                w_rt_tracked;
    logic                w_rd_tracked;
    logic [CNT_W-1:0]    w_cnt_rs;
    logic [CNT_W-1:0]    w_cnt_rt;
    logic [CNT_W-1:0]    w_cnt_rd;
    logic [CNT_W-1:0]    w_cnt_wb;
    logic                w_haz_rs;
    logic                w_haz_rt;
    logic                w_sat_haz;
    logic                w_stall;
    logic                w_accept;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;

    // With a hardwired zero register, address 0 is invisible to the scoreboard.
    assign w_zr         = (ZERO_REG != 0);
    assign w_wb_tracked = i_wb_write && !(w_zr && (i_wb_addr == '0));
    assign w_rs_tracked = !(w_zr && (i_rs_addr == '0));
    assign w_rt_tracked = !(w_zr && (i_rt_addr == '0));
    assign w_rd_tracked = !(w_zr && (i_issue_rd == '0));

    assign w_cnt_rs = r_cnt[i_rs_addr];
    assign w_cnt_rt = r_cnt[i_rt_addr];
    assign w_cnt_rd = r_cnt[i_issue_rd];
    assign w_cnt_wb = r_cnt[i_wb_addr];

    // A lone producer writing back now is covered by the read bypass.
    assign w_haz_rs = i_issue_uses_rs && w_rs_tracked && (w_cnt_rs != '0)
                   && !((w_cnt_rs == c_CNT_ONE) && w_wb_tracked && (i_wb_addr == i_rs_addr));
    assign w_haz_rt = i_issue_uses_rt && w_rt_tracked && (w_cnt_rt != '0)
                   && !((w_cnt_rt == c_CNT_ONE) && w_wb_tracked && (i_wb_addr == i_rt_addr));
    assign w_sat_haz = i_issue_writes && w_rd_tracked && (w_cnt_rd == c_CNT_MAX)
                   && !(i_wb_write && (i_wb_addr == i_issue_rd));

    assign w_stall  = i_issue_valid && (w_haz_rs || w_haz_rt || w_sat_haz);
    assign w_accept = i_issue_valid && !w_stall;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flags
        assign w_inc[gi] = w_accept && i_issue_writes && w_rd_tracked
                        && (i_issue_rd == ADDR_W'(gi));
        assign w_dec[gi] = w_wb_tracked && (i_wb_addr == ADDR_W'(gi))
                        && (r_cnt[gi] != '0);
        assign o_pend_mask[gi] = (r_cnt[gi] != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] - c_CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb_error <= 1'b0;
        end else if (w_wb_tracked && (w_cnt_wb == '0)) begin
            r_sb_error <= 1'b1;
        end
    end

    assign o_stall    = w_stall;
    assign o_sb_error = r_sb_error;

endmodule
`default_nettype wire

// File: rtl/reg_file_wb_sink.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_wb_sink
// Description : Register file fed by write-back, two bypassed combinational
//               read ports and a pending-write scoreboard driving decode stall.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_wb_sink
    import reg_file_wb_sink_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W,
    parameter int ADDR_W   = c_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int CNT_W    = c_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wbWrite,
    input  logic [ADDR_W-1:0]       wbAddr,
    input  logic [DATA_W-1:0]       wbData,
    input  logic [ADDR_W-1:0]       rsAddr,
    input  logic [ADDR_W-1:0]       rtAddr,
    output logic [DATA_W-1:0]       rsData,
    output logic [DATA_W-1:0]       rtData,
    input  logic                    issueValid,
    input  logic                    issueUsesRs,
    input  logic                    issueUsesRt,
    input  logic                    issueWrites,
    input  logic [ADDR_W-1:0]       issueRd,
    output logic                    stall,
    output logic [(2**ADDR_W)-1:0]  pendMask,
    output logic                    sbError
);

    localparam int c_NUM = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [c_NUM];
    logic              w_zr;
    logic              w_wb_ok;

    assign w_zr    = (ZERO_REG != 0);
    assign w_wb_ok = wbWrite && !(w_zr && (wbAddr == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_ok) begin
            r_regs[wbAddr] <= wbData;
        end
    end

    // Same-cycle write-back takes priority over stored contents.
    assign rsData = (w_zr && (rsAddr == '0))     ? '0     :
                    (w_wb_ok && (wbAddr == rsAddr)) ? wbData : r_regs[rsAddr];
    assign rtData = (w_zr && (rtAddr == '0))     ? '0     :
                    (w_wb_ok && (wbAddr == rtAddr)) ? wbData : r_regs[rtAddr];

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W),
        .ZERO_REG (ZERO_REG),
        .NUM_REGS (c_NUM)
    ) u_scoreboard (
        .clk             (clk),
        .rst             (reset),
        .i_wb_write      (wbWrite),
        .i_wb_addr       (wbAddr),
        .i_rs_addr       (rsAddr),
        .i_rt_addr       (rtAddr),
        .i_issue_valid   (issueValid),
        .i_issue_uses_rs (issueUsesRs),
        .i_issue_uses_rt (issueUsesRt),
        .i_issue_writes  (issueWrites),
        .i_issue_rd      (issueRd),
        .o_stall         (stall),
        .o_pend_mask     (pendMask),
        .o_sb_error      (sbError)
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_wb_sink
// Description : Directed vector bench for reg_file_wb_sink, ZERO_REG=0 and 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_wb_sink;
    import reg_file_wb_sink_pkg::*;

    typedef struct {
        logic       rst;
        logic       wb;
        reg_addr_t  wa;
        data_word_t wd;
        reg_addr_t  rs;
        reg_addr_t  rt;
        logic       iv;
        logic       ur;
        logic       ut;
        logic       iw;
        reg_addr_t  rd;
        data_word_t ers;
        data_word_t ert;
        logic       est;
        logic [7:0] epm;
        logic       eerr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       wbWrite;
    reg_addr_t  wbAddr;
    data_word_t wbData;
    reg_addr_t  rsAddr;
    reg_addr_t  rtAddr;
    logic       issueValid;
    logic       issueUsesRs;
    logic       issueUsesRt;
    logic       issueWrites;
    reg_addr_t  issueRd;

    data_word_t rsData0, rtData0, rsData1, rtData1;
    logic       stall0, stall1, sbError0, sbError1;
    logic [7:0] pendMask0, pendMask1;

    int n_cmp  = 0;
    int n_fail = 0;

    vec_t main_tbl[$];
    vec_t zr_tbl[$];

    always #5 clk = ~clk;

    reg_file_wb_sink #(.ZERO_REG(0)) dut0 (
        .clk(clk), .reset(reset), .wbWrite(wbWrite), .wbAddr(wbAddr), .wbData(wbData),
        .rsAddr(rsAddr), .rtAddr(rtAddr), .rsData(rsData0), .rtData(rtData0),
        .issueValid(issueValid), .issueUsesRs(issueUsesRs), .issueUsesRt(issueUsesRt),
        .issueWrites(issueWrites), .issueRd(issueRd), .stall(stall0),
        .pendMask(pendMask0), .sbError(sbError0)
    );

    reg_file_wb_sink #(.ZERO_REG(1)) dut1 (
        .clk(clk), .reset(reset), .wbWrite(wbWrite), .wbAddr(wbAddr), .wbData(wbData),
        .rsAddr(rsAddr), .rtAddr(rtAddr), .rsData(rsData1), .rtData(rtData1),
        .issueValid(issueValid), .issueUsesRs(issueUsesRs), .issueUsesRt(issueUsesRt),
        .issueWrites(issueWrites), .issueRd(issueRd), .stall(stall1),
        .pendMask(pendMask1), .sbError(sbError1)
    );

    function automatic vec_t mk(
        input logic rst, input logic wb, input int wa, input int wd,
        input int rs, input int rt,
        input logic iv, input logic ur, input logic ut, input logic iw, input int rd,
        input int ers, input int ert, input logic est, input int epm, input logic eerr);
        vec_t v;
        v.rst = rst;  v.wb = wb;  v.wa = reg_addr_t'(wa);  v.wd = data_word_t'(wd);
        v.rs = reg_addr_t'(rs);  v.rt = reg_addr_t'(rt);
        v.iv = iv;  v.ur = ur;  v.ut = ut;  v.iw = iw;  v.rd = reg_addr_t'(rd);
        v.ers = data_word_t'(ers);  v.ert = data_word_t'(ert);
        v.est = est;  v.epm = 8'(epm);  v.eerr = eerr;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int which, input string tag, input int idx);
        @(negedge clk);
        reset       = v.rst;
        wbWrite     = v.wb;
        wbAddr      = v.wa;
        wbData      = v.wd;
        rsAddr      = v.rs;
        rtAddr      = v.rt;
        issueValid  = v.iv;
        issueUsesRs = v.ur;
        issueUsesRt = v.ut;
        issueWrites = v.iw;
        issueRd     = v.rd;
        #1;
        if (which == 0) begin
            check({tag, ".rsData"},   idx, 32'(rsData0),   32'(v.ers));
            check({tag, ".rtData"},   idx, 32'(rtData0),   32'(v.ert));
            check({tag, ".stall"},    idx, 32'(stall0),    32'(v.est));
            check({tag, ".pendMask"}, idx, 32'(pendMask0), 32'(v.epm));
            check({tag, ".sbError"},  idx, 32'(sbError0),  32'(v.eerr));
        end else begin
            check({tag, ".rsData"},   idx, 32'(rsData1),   32'(v.ers));
            check({tag, ".rtData"},   idx, 32'(rtData1),   32'(v.ert));
            check({tag, ".stall"},    idx, 32'(stall1),    32'(v.est));
            check({tag, ".pendMask"}, idx, 32'(pendMask1), 32'(v.epm));
            check({tag, ".sbError"},  idx, 32'(sbError1),  32'(v.eerr));
        end
    endtask

    initial begin
        //                 rst wb wa wd       rs rt iv ur ut iw rd  ers      ert      st pm    err
        main_tbl.push_back(mk(0, 0, 0, 'h0000, 5, 0, 1, 0, 0, 1, 5, 'h0000, 'h0000, 0, 'h00, 0));
        main_tbl.push_back(mk(0, 1, 5, 'hBEEF, 5, 5, 0, 0, 0, 0, 0, 'hBEEF, 'hBEEF, 0, 'h20, 0));
        main_tbl.push_back(mk(0, 0, 0, 'h0000, 5, 0, 0, 0, 0, 0, 0, 'hBEEF, 'h0000, 0, 'h00, 0));
        main_tbl.push_back(mk(0, 0, 0, 'h0000, 3, 3, 1, 0, 0, 1, 3, 'h0000, 'h0000, 0, 'h00, 0));
        main_tbl.push_back(mk(0, 0, 0, 'h0000, 3, 0, 1, 1, 0, 0, 0, 'h0000, 'h0000, 1, 'h08, 0));
        main_tbl.push_back(mk(0, 1, 3, 'h1234, 3, 0, 1, 1, 0, 0, 0, 'h1234, 'h0000, 0, 'h08, 0));
        main_tbl.push_back(mk(0, 0, 0, 'h0000, 3, 5, 0, 0, 0, 0, 0, 'h1234, 'hBEEF, 0, 'h00, 0));
        main_tbl.push_back(mk(0, 0, 0, 'h0000, 2, 2, 1, 0, 0, 1, 2, 'h0000, 'h0000, 0, 'h00, 0));
        main_tbl.push_back(mk(0, 0, 0, 'h0000, 2, 2, 1, 0, 0, 1, 2, 'h0000, 'h0000, 0, 'h04, 0));
        main_tbl.push_back(mk(0, 0, 0, 'h0000, 2, 2, 1, 0, 0, 1, 2, 'h0000, 'h0000, 0, 'h04, 0));
        main_tbl.push_back(mk(0, 0, 0, 'h0000, 2, 2, 1, 0, 0, 1, 2, 'h0000, 'h0000, 1, 'h04, 0));
        main_tbl.push_back(mk(0, 1, 2, 'hAAAA, 2, 0, 1, 1, 0, 0, 0, 'hAAAA, 'h0000, 1, 'h04, 0));
        main_tbl.push_back(mk(0, 0, 0, 'h0000, 2, 2, 1, 0, 0, 1, 2, 'hAAAA, 'hAAAA, 0, 'h04, 0));
        main_tbl.push_back(mk(0, 1, 2, 'hCCCC, 2, 0, 1, 0, 0, 1, 2, 'hCCCC, 'h0000, 0, 'h04, 0));
        main_tbl.push_back(mk(0, 0, 0, 'h0000, 0, 2, 1, 0, 1, 0, 0, 'h0000, 'hCCCC, 1, 'h04, 0));
        main_tbl.push_back(mk(0, 1, 2, 'h1111, 0, 2, 0, 0, 0, 0, 0, 'h0000, 'h1111, 0, 'h04, 0));
        main_tbl.push_back(mk(0, 1, 2, 'h2222, 0, 2, 0, 0, 0, 0, 0, 'h0000, 'h2222, 0, 'h04, 0));
        main_tbl.push_back(mk(0, 1, 2, 'hDDDD, 2, 2, 1, 1, 1, 1, 2, 'hDDDD, 'hDDDD, 0, 'h04, 0));
        main_tbl.push_back(mk(0, 1, 2, 'hEEEE, 2, 0, 0, 0, 0, 0, 0, 'hEEEE, 'h0000, 0, 'h04, 0));
        main_tbl.push_back(mk(0, 0, 0, 'h0000, 2, 0, 0, 0, 0, 0, 0, 'hEEEE, 'h0000, 0, 'h00, 0));
        main_tbl.push_back(mk(0, 1, 6, 'h6666, 6, 0, 0, 0, 0, 0, 0, 'h6666, 'h0000, 0, 'h00, 0));
        main_tbl.push_back(mk(0, 0, 0, 'h0000, 6, 5, 0, 0, 0, 0, 0, 'h6666, 'hBEEF, 0, 'h00, 1));
        main_tbl.push_back(mk(0, 0, 0, 'h0000, 0, 0, 1, 0, 0, 1, 1, 'h0000, 'h0000, 0, 'h00, 1));
        main_tbl.push_back(mk(0, 0, 0, 'h0000, 1, 1, 0, 0, 0, 0, 0, 'h0000, 'h0000, 0, 'h02, 1));
        main_tbl.push_back(mk(1, 0, 0, 'h0000, 6, 0, 0, 0, 0, 0, 0, 'h6666, 'h0000, 0, 'h02, 1));
        main_tbl.push_back(mk(0, 0, 0, 'h0000, 6, 3, 0, 0, 0, 0, 0, 'h0000, 'h0000, 0, 'h00, 0));
        main_tbl.push_back(mk(0, 0, 0, 'h0000, 0, 0, 1, 0, 0, 1, 0, 'h0000, 'h0000, 0, 'h00, 0));
        main_tbl.push_back(mk(0, 1, 0, 'h0F0F, 0, 0, 0, 0, 0, 0, 0, 'h0F0F, 'h0F0F, 0, 'h01, 0));
        main_tbl.push_back(mk(0, 0, 0, 'h0000, 0, 0, 0, 0, 0, 0, 0, 'h0F0F, 'h0F0F, 0, 'h00, 0));

        // ZERO_REG=1 instance: register 0 is inert, reset clears pending counts.
        zr_tbl.push_back(mk(0, 1, 0, 'hFFFF, 0, 0, 1, 1, 1, 1, 0, 'h0000, 'h0000, 0, 'h00, 0));
        zr_tbl.push_back(mk(0, 0, 0, 'h0000, 0, 0, 0, 0, 0, 0, 0, 'h0000, 'h0000, 0, 'h00, 0));
        zr_tbl.push_back(mk(0, 0, 0, 'h0000, 1, 1, 1, 0, 0, 1, 1, 'h0000, 'h0000, 0, 'h00, 0));
        zr_tbl.push_back(mk(0, 0, 0, 'h0000, 1, 1, 1, 0, 0, 1, 1, 'h0000, 'h0000, 0, 'h02, 0));
        zr_tbl.push_back(mk(1, 0, 0, 'h0000, 1, 0, 1, 1, 0, 0, 0, 'h0000, 'h0000, 1, 'h02, 0));
        zr_tbl.push_back(mk(0, 0, 0, 'h0000, 1, 0, 1, 1, 0, 0, 0, 'h0000, 'h0000, 0, 'h00, 0));

        reset = 1'b1;  wbWrite = 1'b0;  wbAddr = '0;  wbData = '0;
        rsAddr = '0;  rtAddr = '0;  issueValid = 1'b0;  issueUsesRs = 1'b0;
        issueUsesRt = 1'b0;  issueWrites = 1'b0;  issueRd = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            rsAddr = reg_addr_t'(a);
            rtAddr = reg_addr_t'(7 - a);
            #1;
            check("rst.rsData", a, 32'(rsData0), 32'h0);
            check("rst.rtData", a, 32'(rtData0), 32'h0);
            if (a == 0) begin
                check("rst.stall",    a, 32'(stall0),    32'h0);
                check("rst.pendMask", a, 32'(pendMask0), 32'h0);
                check("rst.sbError",  a, 32'(sbError0),  32'h0);
            end
        end

        foreach (main_tbl[i]) step(main_tbl[i], 0, "main", i);
        foreach (zr_tbl[i])   step(zr_tbl[i],   1, "zr",   i);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
